// File: rtl/camo_pkg.sv
// Shared definitions for the camouflaged gate bank: cell-function encodings,
// key-load FSM states and the single-cell evaluation function.
package camo_pkg;

  localparam logic [1:0] CAMO_NAND = 2'b00;
  localparam logic [1:0] CAMO_XOR0 = 2'b01;
  localparam logic [1:0] CAMO_NOR  = 2'b10;
  localparam logic [1:0] CAMO_XOR1 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_FLUSH  = 2'd3
  } key_st_e;

  // s0 set selects XOR regardless of s1; otherwise s1 picks NOR over NAND.
  function automatic logic camo_eval(input logic [1:0] sel, input logic a, input logic b);
    logic r;
    case (sel)
      CAMO_NAND: r = ~(a & b);
      CAMO_NOR:  r = ~(a | b);
      default:   r = a ^ b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/camo_cell.sv
// One key-programmable camouflaged 2-input cell, purely combinational.
module camo_cell
  import camo_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  assign y = camo_eval(sel, a, b);

endmodule

// File: rtl/camo_gate_bank.sv
// Bank of camouflaged cells with a streamed, length-checked key that is
// committed atomically to the active key register; outputs are registered.
module camo_gate_bank
  import camo_pkg::*;
#(
  parameter int NUM_CELLS = 8,
  parameter int LOAD_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [LOAD_W-1:0]    key_data,
  input  logic                 key_last,
  output logic                 key_err,
  output logic                 armed,
  input  logic                 in_valid,
  input  logic [NUM_CELLS-1:0] a,
  input  logic [NUM_CELLS-1:0] b,
  output logic                 out_valid,
  output logic [NUM_CELLS-1:0] y
);

  localparam int KEY_W  = 2 * NUM_CELLS;
  localparam int NWORDS = (KEY_W + LOAD_W - 1) / LOAD_W;
  localparam int CW     = $clog2(NWORDS + 1);

  key_st_e              r_state;
  logic                 r_key_ready;
  logic                 r_key_err;
  logic                 r_armed;
  logic [CW-1:0]        r_cnt;
  logic [KEY_W-1:0]     r_shadow;
  logic [KEY_W-1:0]     r_active;
  logic                 r_out_valid;
  logic [NUM_CELLS-1:0] r_y;

  logic                 w_acc;
  logic                 w_wr;
  logic [CW-1:0]        w_cnt_nxt;
  logic [CW-1:0]        w_widx;
  logic [KEY_W-1:0]     w_sh_nxt;
  logic [NUM_CELLS-1:0] w_y;

  assign w_acc     = key_valid & r_key_ready;
  assign w_wr      = w_acc & ((r_state == ST_IDLE) | (r_state == ST_LOAD));
  assign w_cnt_nxt = r_cnt + CW'(1);
  assign w_widx    = (r_state == ST_IDLE) ? '0 : r_cnt;

  // Each shadow bit belongs to exactly one key word; excess bits of the last word drop.
  for (genvar j = 0; j < KEY_W; j++) begin : g_sh
    localparam logic [CW-1:0] WI = CW'(j / LOAD_W);
    assign w_sh_nxt[j] = (w_widx == WI) ? key_data[j % LOAD_W] : r_shadow[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_shadow <= '0;
    else if (w_wr) r_shadow <= w_sh_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_key_ready <= 1'b1;
      r_key_err   <= 1'b0;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_active    <= '0;
    end else begin
      r_key_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_acc) begin
          r_cnt <= CW'(1);
          if (key_last) begin
            if (NWORDS == 1) begin
              r_state     <= ST_COMMIT;
              r_key_ready <= 1'b0;
            end else begin
              r_key_err <= 1'b1;
            end
          end else begin
            r_state <= (NWORDS == 1) ? ST_FLUSH : ST_LOAD;
          end
        end
        ST_LOAD: if (w_acc) begin
          r_cnt <= w_cnt_nxt;
          if (key_last) begin
            if (w_cnt_nxt == CW'(NWORDS)) begin
              r_state     <= ST_COMMIT;
              r_key_ready <= 1'b0;
            end else begin
              r_key_err <= 1'b1;
              r_state   <= ST_IDLE;
            end
          end else if (w_cnt_nxt == CW'(NWORDS)) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: if (w_acc && key_last) begin
          r_key_err <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_COMMIT: begin
          r_active    <= r_shadow;
          r_armed     <= 1'b1;
          r_state     <= ST_IDLE;
          r_key_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_key_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    camo_cell u_cell (
      .sel (r_active[2*i +: 2]),
      .a   (a[i]),
      .b   (b[i]),
      .y   (w_y[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) r_y <= r_armed ? w_y : '0;
    end
  end

  assign key_ready = r_key_ready;
  assign key_err   = r_key_err;
  assign armed     = r_armed;
  assign out_valid = r_out_valid;
  assign y         = r_y;

endmodule
